// File: rtl/load_store_unit_if.sv
// Request, DataCache and writeback signals of the load/store sequencer.
// master = pipeline/cache side, slave = load_store_unit.
interface load_store_unit_if;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned RegWidth  = 5;

  logic                 reqValid;
  logic                 reqReady;
  logic                 reqLoad;
  logic [1:0]           reqSize;
  logic                 reqSigned;
  logic [DataWidth-1:0] reqAddr;
  logic [DataWidth-1:0] reqData;
  logic [RegWidth-1:0]  reqRd;
  logic                 memRead;
  logic                 memWrite;
  logic                 memToReg;
  logic [DataWidth-1:0] address;
  logic [DataWidth-1:0] writeData;
  logic [DataWidth-1:0] readData;
  logic                 rspValid;
  logic [DataWidth-1:0] rspData;
  logic [RegWidth-1:0]  rspRd;
  logic                 misaligned;

  modport master (
    output reqValid, reqLoad, reqSize, reqSigned, reqAddr, reqData, reqRd, readData,
    input  reqReady, memRead, memWrite, memToReg, address, writeData,
           rspValid, rspData, rspRd, misaligned
  );

  modport slave (
    input  reqValid, reqLoad, reqSize, reqSigned, reqAddr, reqData, reqRd, readData,
    output reqReady, memRead, memWrite, memToReg, address, writeData,
           rspValid, rspData, rspRd, misaligned
  );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store sequencer in front of the DataCache: aligned word
// access, sub-word read-modify-write stores, sign/zero-extended loads.
module load_store_unit (
  input logic              clock,
  input logic              resetN,
  load_store_unit_if.slave bus
);
  localparam int unsigned DataWidth = 32;
  localparam int unsigned RegWidth  = 5;
  localparam logic [1:0]  SizeByte  = 2'b00;
  localparam logic [1:0]  SizeHalf  = 2'b01;
  localparam logic [1:0]  SizeWord  = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, DATA, WR, RESP} lsuState;

  lsuState state, stateNext;

  logic [DataWidth-1:0] addrQ;
  logic [1:0]           sizeQ;
  logic                 signedQ;
  logic                 loadQ;
  logic [15:0]          dataQ;
  logic [RegWidth-1:0]  rdQ;

  logic                 readyQ, memReadQ, memWriteQ, memToRegQ, rspValidQ, misalignedQ;
  logic [DataWidth-1:0] addressQ, writeDataQ, rspDataQ;
  logic [RegWidth-1:0]  rspRdQ;

  logic                 take;
  logic                 readyNext, memReadNext, memWriteNext, memToRegNext;
  logic                 rspValidNext, misalignedNext;
  logic [DataWidth-1:0] addressNext, writeDataNext, rspDataNext;
  logic [RegWidth-1:0]  rspRdNext;
  logic                 illegalC;
  logic [7:0]           laneByte;
  logic [15:0]          laneHalf;
  logic [DataWidth-1:0] loadWord, mergeWord;

  // Lane extraction/extension for loads and lane merge for sub-word stores.
  always_comb begin
    illegalC = (bus.reqSize == 2'b11)
            || (bus.reqSize == SizeHalf && bus.reqAddr[0])
            || (bus.reqSize == SizeWord && bus.reqAddr[1:0] != 2'b00);
    case (addrQ[1:0])
      2'd0:    laneByte = bus.readData[7:0];
      2'd1:    laneByte = bus.readData[15:8];
      2'd2:    laneByte = bus.readData[23:16];
      default: laneByte = bus.readData[31:24];
    endcase
    laneHalf = addrQ[1] ? bus.readData[31:16] : bus.readData[15:0];
    case (sizeQ)
      SizeByte: loadWord = signedQ ? {{24{laneByte[7]}}, laneByte} : {24'h0, laneByte};
      SizeHalf: loadWord = signedQ ? {{16{laneHalf[15]}}, laneHalf} : {16'h0, laneHalf};
      default:  loadWord = bus.readData;
    endcase
    mergeWord = bus.readData;
    if (sizeQ == SizeByte) begin
      case (addrQ[1:0])
        2'd0:    mergeWord[7:0]   = dataQ[7:0];
        2'd1:    mergeWord[15:8]  = dataQ[7:0];
        2'd2:    mergeWord[23:16] = dataQ[7:0];
        default: mergeWord[31:24] = dataQ[7:0];
      endcase
    end else if (addrQ[1]) begin
      mergeWord[31:16] = dataQ;
    end else begin
      mergeWord[15:0] = dataQ;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    stateNext      = state;
    take           = 1'b0;
    memReadNext    = 1'b0;
    memWriteNext   = 1'b0;
    memToRegNext   = 1'b0;
    addressNext    = '0;
    writeDataNext  = '0;
    rspValidNext   = 1'b0;
    rspDataNext    = rspDataQ;
    rspRdNext      = rspRdQ;
    misalignedNext = 1'b0;
    case (state)
      IDLE: begin
        if (bus.reqValid && readyQ) begin
          take = 1'b1;
          if (illegalC) begin
            misalignedNext = 1'b1;
          end else if (bus.reqLoad || bus.reqSize != SizeWord) begin
            stateNext    = RD;
            memReadNext  = 1'b1;
            memToRegNext = bus.reqLoad;
            addressNext  = {bus.reqAddr[31:2], 2'b00};
          end else begin
            stateNext     = WR;
            memWriteNext  = 1'b1;
            addressNext   = {bus.reqAddr[31:2], 2'b00};
            writeDataNext = bus.reqData;
          end
        end
      end
      RD:   stateNext = DATA;
      DATA: begin
        if (loadQ) begin
          stateNext    = RESP;
          rspValidNext = 1'b1;
          rspDataNext  = loadWord;
          rspRdNext    = rdQ;
        end else begin
          stateNext     = WR;
          memWriteNext  = 1'b1;
          addressNext   = {addrQ[31:2], 2'b00};
          writeDataNext = mergeWord;
        end
      end
      WR:      stateNext = IDLE;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    readyNext = (stateNext == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state       <= IDLE;
      addrQ       <= '0;
      sizeQ       <= '0;
      signedQ     <= 1'b0;
      loadQ       <= 1'b0;
      dataQ       <= '0;
      rdQ         <= '0;
      readyQ      <= 1'b0;
      memReadQ    <= 1'b0;
      memWriteQ   <= 1'b0;
      memToRegQ   <= 1'b0;
      addressQ    <= '0;
      writeDataQ  <= '0;
      rspValidQ   <= 1'b0;
      rspDataQ    <= '0;
      rspRdQ      <= '0;
      misalignedQ <= 1'b0;
    end else begin
      state       <= stateNext;
      readyQ      <= readyNext;
      memReadQ    <= memReadNext;
      memWriteQ   <= memWriteNext;
      memToRegQ   <= memToRegNext;
      addressQ    <= addressNext;
      writeDataQ  <= writeDataNext;
      rspValidQ   <= rspValidNext;
      rspDataQ    <= rspDataNext;
      rspRdQ      <= rspRdNext;
      misalignedQ <= misalignedNext;
      if (take) begin
        addrQ   <= bus.reqAddr;
        sizeQ   <= bus.reqSize;
        signedQ <= bus.reqSigned;
        loadQ   <= bus.reqLoad;
        dataQ   <= bus.reqData[15:0];
        rdQ     <= bus.reqRd;
      end
    end
  end

  assign bus.reqReady   = readyQ;
  assign bus.memRead    = memReadQ;
  assign bus.memWrite   = memWriteQ;
  assign bus.memToReg   = memToRegQ;
  assign bus.address    = addressQ;
  assign bus.writeData  = writeDataQ;
  assign bus.rspValid   = rspValidQ;
  assign bus.rspData    = rspDataQ;
  assign bus.rspRd      = rspRdQ;
  assign bus.misaligned = misalignedQ;
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store sequencer that sits directly upstream of the DataCache. It accepts one load or store per handshake from the execute/memory pipeline register and drives the DataCache's memRead/memWrite/memToReg/address/writeData ports. It performs word-aligned access, sub-word read-modify-write for byte/halfword stores, and sign/zero extension for loads. Load results go to the writeback stage with the destination register number.

## Interface
Parameters: none (32-bit data/address, 5-bit register index fixed).

- clock  in  1  rising-edge clock shared with DataCache
- resetN  in  1  synchronous, active-low reset
- reqValid  in  1  request present
- reqReady  out  1  unit can accept; transfer when reqValid && reqReady at a rising edge
- reqLoad  in  1  1 = load, 0 = store
- reqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- reqSigned  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- reqAddr  in  32  byte address
- reqData  in  32  store data, right-justified
- reqRd  in  5  load destination register
- memRead  out  1  to DataCache
- memWrite  out  1  to DataCache
- memToReg  out  1  to DataCache, 1 during load reads
- address  out  32  to DataCache, always word-aligned ({addr[31:2],2'b00})
- writeData  out  32  to DataCache
- readData  in  32  from DataCache, valid the cycle after memRead is asserted
- rspValid  out  1  one-cycle load result strobe
- rspData  out  32  extended load result
- rspRd  out  5  destination register of rspData
- misaligned  out  1  one-cycle fault strobe for a rejected request

## Operation
- Little-endian. Byte lane k = addr[1:0] occupies bits [8k+7:8k]. Halfword lane addr[1] occupies bits [16·addr[1]+15:16·addr[1]].
- States: IDLE, RD, DATA, WR, RESP.
- IDLE: reqReady=1, all cache strobes 0. On handshake, latch the request fields, then:
  - misaligned (half with addr[0]=1, word with addr[1:0]≠0, or size 11): pulse misaligned next cycle, stay IDLE, no cache access.
  - load or byte/half store → RD.
  - word store → WR.
- RD: memRead=1, address=aligned latched address, memToReg=reqLoad latched. → DATA.
- DATA: readData valid.
  - Load: extract lane, extend per size/signed, register into rspData/rspRd → RESP.
  - Sub-word store: merge the low byte/half of the latched data into the selected lane of readData, other lanes unchanged, register as the write buffer → WR.
- WR: memWrite=1, address=aligned address, writeData=write buffer (word store: latched reqData). → IDLE.
- RESP: rspValid=1 with rspData and rspRd stable. → IDLE. No response backpressure.
- Stores produce no rspValid.
- reqReady=0 in every state except IDLE.

## Timing
- Handshake edge = E0. Load: RD in cycle 1, DATA in cycle 2, rspValid in cycle 3. Next accept is possible at the end of cycle 4.
- Word store: WR in cycle 1, 2 cycles per store.
- Sub-word store: RD in cycle 1, DATA in cycle 2, WR in cycle 3, 4 cycles per store.
- Misaligned request: misaligned=1 in cycle 1. reqReady stays 1, so a new request can be accepted at the end of cycle 1.
- Reset (resetN low at an edge):
  - next state IDLE.
  - memRead, memWrite, memToReg, rspValid, misaligned = 0.
  - address, writeData, rspData = 0; rspRd = 0.
  - reqReady=0 while resetN is low.
- Reset mid-operation aborts the operation. No memWrite is issued after the reset edge, so a partial read-modify-write is dropped (memory unchanged) and a pending load produces no rspValid.
- Address and writeData are 0 in IDLE, RESP and DATA. They are driven only in RD/WR.
- reqValid held across a non-ready cycle is simply accepted later. No input is sampled outside IDLE.

## Test plan
Bench models DataCache as a 32-bit word memory with memRead sampled at posedge and readData registered at that same edge.
- Reset: resetN=0 for 2 cycles mid-load → memRead/memWrite/rspValid=0, no rspValid afterward, reqReady=1 the first cycle after resetN=1.
- Word load: mem[0x100]=0x8899AABB, load word 0x100 rd=3 → memRead in cycle 1 with address 0x100, rspValid in cycle 3 with rspData=0x8899AABB, rspRd=3.
- Signed/unsigned byte and half: same word. Load signed byte 0x102 → 0xFFFFFF99. Unsigned byte 0x102 → 0x00000099. Signed half 0x100 → 0xFFFFAABB. Unsigned half 0x102 → 0x00008899.
- Sub-word store RMW: mem[0x200]=0x11223344, store byte 0x201 data 0xDEADBEEF → RD cycle 1, memWrite cycle 3 with writeData=0x1122EF44. A halfword store of 0xCAFE at 0x202 then yields 0xCAFEEF44.
- Word store back-to-back: two word stores to 0x300/0x304 → memWrite in cycles 1 and 3, reqReady low in cycles 1 and 3 only.
- Misaligned: word load at 0x102 → misaligned=1 in cycle 1, no memRead, no rspValid. A valid load issued the next cycle completes normally.
